mem_access: RTL and testbench

// Memory stage of the pipeline, directly upstream of writeback. Issues word-aligned load/store

---
 rtl/mem_access.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access
//  Purpose  : Pipeline memory stage ahead of writeback. Issues word-aligned
//             load/store requests to a synchronous data memory, builds byte
//             enables and lane-aligned store data, and splits accesses that
//             cross a word boundary into two beats. The stage payload is
//             registered so it reaches writeback together with read data.
//  Ports    : clk, rst (sync, active-high), halt (freeze)
//             bubble_in/opcode_in/is_load_in/is_store_in/addr_in/
//             store_data_in/tgt_in_1/2/alu_result_1/2_in/exc_in/sideband_in
//                 - incoming op from execute
//             stall_out                    - hold upstream during beat 1
//             mem_addr/mem_re/mem_we/mem_wdata - combinational memory request
//             *_out payload                - registered payload to writeback
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int SIDEBAND_W = 8,
    parameter bit SPLIT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  bubble_in,
    input  logic [4:0]            opcode_in,
    input  logic                  is_load_in,
    input  logic                  is_store_in,
    input  logic [31:0]           addr_in,
    input  logic [31:0]           store_data_in,
    input  logic [4:0]            tgt_in_1,
    input  logic [4:0]            tgt_in_2,
    input  logic [31:0]           alu_result_1_in,
    input  logic [31:0]           alu_result_2_in,
    input  logic [7:0]            exc_in,
    input  logic [SIDEBAND_W-1:0] sideband_in,
    output logic                  stall_out,
    output logic [31:0]           mem_addr,
    output logic                  mem_re,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_wdata,
    output logic                  bubble_out,
    output logic [4:0]            opcode_out,
    output logic                  is_load_out,
    output logic                  is_store_out,
    output logic                  is_misaligned_out,
    output logic [31:0]           addr_out,
    output logic [4:0]            tgt_out_1,
    output logic [4:0]            tgt_out_2,
    output logic [31:0]           alu_result_1_out,
    output logic [31:0]           alu_result_2_out,
    output logic [7:0]            exc_out,
    output logic [SIDEBAND_W-1:0] sideband_out
);

    typedef enum logic [0:0] {
        ST_ONE    = 1'b0,
        ST_SPLIT2 = 1'b1
    } state_t;

    localparam logic [7:0] c_EXC_MISALIGNED = 8'h04;

    state_t r_state;
    state_t w_state_nxt;

    // Captured copy of a split op, replayed for beat 2.
    logic [4:0]            r_h_opcode;
    logic                  r_h_is_load;
    logic                  r_h_is_store;
    logic [31:0]           r_h_addr;
    logic [31:0]           r_h_data;
    logic [4:0]            r_h_tgt_1;
    logic [4:0]            r_h_tgt_2;
    logic [31:0]           r_h_alu_1;
    logic [31:0]           r_h_alu_2;
    logic [SIDEBAND_W-1:0] r_h_sideband;

    // Operation currently driving the request: live input in ONE, hold regs in SPLIT2.
    logic [4:0]  w_opc;
    logic        w_ld;
    logic        w_st;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    logic [1:0]  w_off;
    logic [7:0]  w_lanes;
    logic [5:0]  w_sh;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_active;
    logic        w_split;
    logic        w_mis_flag;
    logic [31:0] w_mem_addr;
    logic        w_mem_re;
    logic [3:0]  w_mem_we;
    logic [31:0] w_mem_wdata;
    logic        w_stall;

    assign w_opc  = (r_state == ST_SPLIT2) ? r_h_opcode   : opcode_in;
    assign w_ld   = (r_state == ST_SPLIT2) ? r_h_is_load  : is_load_in;
    assign w_st   = (r_state == ST_SPLIT2) ? r_h_is_store : is_store_in;
    assign w_addr = (r_state == ST_SPLIT2) ? r_h_addr     : addr_in;
    assign w_data = (r_state == ST_SPLIT2) ? r_h_data     : store_data_in;

    always_comb begin
        w_mask = 4'h0;
        if (w_opc >= 5'd3 && w_opc <= 5'd5)       w_mask = 4'hf;
        else if (w_opc >= 5'd6 && w_opc <= 5'd8)  w_mask = 4'h3;
        else if (w_opc >= 5'd9 && w_opc <= 5'd11) w_mask = 4'h1;
    end

    // Lanes 7:4 of the shifted mask belong to the next word; any bit there
    // means the access crosses a word boundary.
    assign w_off        = w_addr[1:0];
    assign w_lanes      = {4'b0000, w_mask} << w_off;
    assign w_sh         = 6'd32 - {1'b0, w_off, 3'b000};
    assign w_mem_op     = (w_mask != 4'h0) && (w_ld || w_st);
    assign w_misaligned = w_mem_op && (w_lanes[7:4] != 4'h0);
    assign w_active     = !bubble_in && (exc_in == 8'h00);
    assign w_split      = (r_state == ST_ONE) && w_active && w_misaligned && (SPLIT_EN == 1'b1);
    assign w_mis_flag   = (r_state == ST_ONE) && w_active && w_misaligned && (SPLIT_EN == 1'b0);

    always_comb begin
        w_state_nxt = r_state;
        w_mem_addr  = {w_addr[31:2], 2'b00};
        w_mem_re    = 1'b0;
        w_mem_we    = 4'h0;
        w_mem_wdata = w_data << {w_off, 3'b000};
        w_stall     = 1'b0;
        case (r_state)
            ST_ONE: begin
                if (w_active && !w_mis_flag) begin
                    w_mem_re = w_ld;
                    if (w_st) w_mem_we = w_lanes[3:0];
                end
                w_stall = w_split;
                if (w_split) w_state_nxt = ST_SPLIT2;
            end
            ST_SPLIT2: begin
                w_mem_addr  = {w_addr[31:2], 2'b00} + 32'd4;
                w_mem_re    = w_ld;
                if (w_st) w_mem_we = w_lanes[7:4];
                w_mem_wdata = w_data >> w_sh;
                w_state_nxt = ST_ONE;
            end
            default: w_state_nxt = ST_ONE;
        endcase
        // A frozen cycle must not repeat a write that is re-issued on release.
        if (halt) w_mem_we = 4'h0;
        if (rst) begin
            w_mem_re = 1'b0;
            w_mem_we = 4'h0;
            w_stall  = 1'b0;
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_re    = w_mem_re;
    assign mem_we    = w_mem_we;
    assign mem_wdata = w_mem_wdata;
    assign stall_out = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_ONE;
            bubble_out        <= 1'b1;
            opcode_out        <= '0;
            is_load_out       <= 1'b0;
            is_store_out      <= 1'b0;
            is_misaligned_out <= 1'b0;
            addr_out          <= '0;
            tgt_out_1         <= '0;
            tgt_out_2         <= '0;
            alu_result_1_out  <= '0;
            alu_result_2_out  <= '0;
            exc_out           <= '0;
            sideband_out      <= '0;
            r_h_opcode        <= '0;
            r_h_is_load       <= 1'b0;
            r_h_is_store      <= 1'b0;
            r_h_addr          <= '0;
            r_h_data          <= '0;
            r_h_tgt_1         <= '0;
            r_h_tgt_2         <= '0;
            r_h_alu_1         <= '0;
            r_h_alu_2         <= '0;
            r_h_sideband      <= '0;
        end else if (!halt) begin
            r_state <= w_state_nxt;
            if (r_state == ST_SPLIT2) begin
                // Beat 2 carries the merged result to writeback.
                bubble_out        <= 1'b0;
                opcode_out        <= r_h_opcode;
                is_load_out       <= r_h_is_load;
                is_store_out      <= r_h_is_store;
                is_misaligned_out <= 1'b0;
                addr_out          <= r_h_addr;
                tgt_out_1         <= r_h_tgt_1;
                tgt_out_2         <= r_h_tgt_2;
                alu_result_1_out  <= r_h_alu_1;
                alu_result_2_out  <= r_h_alu_2;
                exc_out           <= 8'h00;
                sideband_out      <= r_h_sideband;
            end else begin
                // Beat 1 of a split goes out as a bubble so writeback only buffers it.
                bubble_out        <= bubble_in | w_split;
                opcode_out        <= opcode_in;
                is_load_out       <= is_load_in;
                is_store_out      <= is_store_in;
                is_misaligned_out <= w_split | w_mis_flag;
                addr_out          <= addr_in;
                tgt_out_1         <= tgt_in_1;
                tgt_out_2         <= tgt_in_2;
                alu_result_1_out  <= alu_result_1_in;
                alu_result_2_out  <= alu_result_2_in;
                exc_out           <= w_mis_flag ? c_EXC_MISALIGNED : exc_in;
                sideband_out      <= sideband_in;
                if (w_split) begin
                    r_h_opcode   <= opcode_in;
                    r_h_is_load  <= is_load_in;
                    r_h_is_store <= is_store_in;
                    r_h_addr     <= addr_in;
                    r_h_data     <= store_data_in;
                    r_h_tgt_1    <= tgt_in_1;
                    r_h_tgt_2    <= tgt_in_2;
                    r_h_alu_1    <= alu_result_1_in;
                    r_h_alu_2    <= alu_result_2_in;
                    r_h_sideband <= sideband_in;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access
//  Purpose  : Self-checking bench for mem_access. Ops are issued at
//             transaction level; a reference model expands each op into its
//             memory beats and pushes expected request/payload entries into
//             queues, and a monitor compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic          bubble_in = 1'b1;
    logic [4:0]    opcode_in = '0;
    logic          is_load_in = 1'b0;
    logic          is_store_in = 1'b0;
    logic [31:0]   addr_in = '0;
    logic [31:0]   store_data_in = '0;
    logic [4:0]    tgt_in_1 = '0;
    logic [4:0]    tgt_in_2 = '0;
    logic [31:0]   alu_result_1_in = '0;
    logic [31:0]   alu_result_2_in = '0;
    logic [7:0]    exc_in = '0;
    logic [SW-1:0] sideband_in = '0;

    logic          stall_out;
    logic [31:0]   mem_addr;
    logic          mem_re;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic          bubble_out;
    logic [4:0]    opcode_out;
    logic          is_load_out;
    logic          is_store_out;
    logic          is_misaligned_out;
    logic [31:0]   addr_out;
    logic [4:0]    tgt_out_1;
    logic [4:0]    tgt_out_2;
    logic [31:0]   alu_result_1_out;
    logic [31:0]   alu_result_2_out;
    logic [7:0]    exc_out;
    logic [SW-1:0] sideband_out;

    mem_access #(.SIDEBAND_W(SW), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .halt(halt), .bubble_in(bubble_in),
        .opcode_in(opcode_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
        .addr_in(addr_in), .store_data_in(store_data_in),
        .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
        .alu_result_1_in(alu_result_1_in), .alu_result_2_in(alu_result_2_in),
        .exc_in(exc_in), .sideband_in(sideband_in),
        .stall_out(stall_out), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .bubble_out(bubble_out), .opcode_out(opcode_out),
        .is_load_out(is_load_out), .is_store_out(is_store_out),
        .is_misaligned_out(is_misaligned_out), .addr_out(addr_out),
        .tgt_out_1(tgt_out_1), .tgt_out_2(tgt_out_2),
        .alu_result_1_out(alu_result_1_out), .alu_result_2_out(alu_result_2_out),
        .exc_out(exc_out), .sideband_out(sideband_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bub; logic [4:0] opc; logic ld; logic st;
        logic [31:0] addr; logic [31:0] data; logic [4:0] t1; logic [4:0] t2;
        logic [31:0] a1; logic [31:0] a2; logic [7:0] exc; logic [SW-1:0] sb;
    } op_t;

    typedef struct {
        int cyc; bit in_rst; logic re; logic [3:0] we; logic stall;
        logic [31:0] addr; bit chk_wd; logic [31:0] wd;
    } req_t;

    typedef struct {
        int cyc; logic bub; logic mis; logic [4:0] opc; logic ld; logic st;
        logic [31:0] addr; logic [4:0] t1; logic [4:0] t2;
        logic [31:0] a1; logic [31:0] a2; logic [7:0] exc; logic [SW-1:0] sb;
    } pay_t;

    req_t req_q[$];
    pay_t pay_q[$];
    pay_t last_pay;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic int nbytes(input logic [4:0] opc);
        if (opc >= 5'd3 && opc <= 5'd5)  return 4;
        if (opc >= 5'd6 && opc <= 5'd8)  return 2;
        if (opc >= 5'd9 && opc <= 5'd11) return 1;
        return 0;
    endfunction

    task automatic drive(input op_t op, input bit h, input bit r);
        @(posedge clk); #1;
        rst = r; halt = h;
        bubble_in = op.bub; opcode_in = op.opc; is_load_in = op.ld; is_store_in = op.st;
        addr_in = op.addr; store_data_in = op.data; tgt_in_1 = op.t1; tgt_in_2 = op.t2;
        alu_result_1_in = op.a1; alu_result_2_in = op.a2; exc_in = op.exc; sideband_in = op.sb;
    endtask

    // Expand one op into its beats; max_beats < 2 stops early, force_h >= 0
    // inserts that many frozen cycles in front of beat 2.
    task automatic run_op(input op_t op, input int max_beats, input int force_h);
        int n = nbytes(op.opc);
        int o = int'(op.addr[1:0]);
        bit act = !op.bub && (op.exc == 8'h00);
        bit mem = (n > 0) && (op.ld || op.st);
        bit split = act && mem && (o + n > 4);
        int nb = split ? 2 : 1;
        logic [31:0] base = {op.addr[31:2], 2'b00};
        logic [7:0] lanes = 8'h00;
        for (int k = 0; k < n; k++) lanes[o + k] = 1'b1;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            req_t rq;
            req_t rh;
            pay_t py;
            int hc;
            rq.in_rst = 1'b0;
            rq.addr   = (b == 0) ? base : base + 32'd4;
            rq.re     = op.ld && act;
            rq.we     = (op.st && act) ? ((b == 0) ? lanes[3:0] : lanes[7:4]) : 4'h0;
            rq.stall  = split && (b == 0);
            rq.chk_wd = (rq.we != 4'h0);
            rq.wd     = (b == 0) ? (op.data << (8 * o)) : (op.data >> (32 - 8 * o));
            py.bub = split ? (b == 0) : op.bub;
            py.mis = split && (b == 0);
            py.exc = split ? 8'h00 : op.exc;
            py.opc = op.opc; py.ld = op.ld; py.st = op.st; py.addr = op.addr;
            py.t1 = op.t1; py.t2 = op.t2; py.a1 = op.a1; py.a2 = op.a2; py.sb = op.sb;
            if (force_h >= 0 && b == 1) hc = force_h;
            else hc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            for (int i = 0; i < hc; i++) begin
                drive(op, 1'b1, 1'b0);
                rh = rq; rh.cyc = cyc; rh.we = 4'h0; rh.chk_wd = 1'b0;
                req_q.push_back(rh);
                last_pay.cyc = cyc + 1;
                pay_q.push_back(last_pay);
            end
            drive(op, 1'b0, 1'b0);
            rq.cyc = cyc;
            req_q.push_back(rq);
            py.cyc = cyc + 1;
            pay_q.push_back(py);
            last_pay = py;
        end
    endtask

    task automatic rst_cycle(input op_t op);
        req_t rq;
        pay_t py;
        drive(op, 1'b0, 1'b1);
        rq.cyc = cyc; rq.in_rst = 1'b1; rq.re = 1'b0; rq.we = 4'h0; rq.stall = 1'b0;
        rq.addr = '0; rq.chk_wd = 1'b0; rq.wd = '0;
        req_q.push_back(rq);
        py.cyc = cyc + 1; py.bub = 1'b1; py.mis = 1'b0; py.opc = '0; py.ld = 1'b0; py.st = 1'b0;
        py.addr = '0; py.t1 = '0; py.t2 = '0; py.a1 = '0; py.a2 = '0; py.exc = '0; py.sb = '0;
        pay_q.push_back(py);
        last_pay = py;
    endtask

    function automatic op_t mk(input logic [4:0] opc, input logic ld, input logic st,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [7:0] exc);
        op_t op;
        op.bub = 1'b0; op.opc = opc; op.ld = ld; op.st = st; op.addr = addr; op.data = data;
        op.t1 = 5'd7; op.t2 = 5'd19; op.a1 = 32'h1234_5678; op.a2 = 32'h9ABC_DEF0;
        op.exc = exc; op.sb = 8'hA5;
        return op;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        int kind = $urandom_range(0, 2);
        op.bub  = ($urandom_range(0, 7) == 0);
        op.opc  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 11));
        op.ld   = (kind == 0);
        op.st   = (kind == 1);
        op.addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
        op.data = $urandom;
        op.t1   = 5'($urandom); op.t2 = 5'($urandom);
        op.a1   = $urandom; op.a2 = $urandom;
        op.exc  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        op.sb   = 8'($urandom);
        return op;
    endfunction

    always @(negedge clk) begin : monitor
        req_t r;
        pay_t p;
        if (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
            r = req_q.pop_front();
            chk("req_slot", 32'(r.cyc), 32'(cyc));
            chk("mem_re", 32'(mem_re), 32'(r.re));
            chk("mem_we", 32'(mem_we), 32'(r.we));
            chk("stall_out", 32'(stall_out), 32'(r.stall));
            if (!r.in_rst) chk("mem_addr", mem_addr, r.addr);
            if (r.chk_wd) chk("mem_wdata", mem_wdata, r.wd);
        end
        if (pay_q.size() > 0 && pay_q[0].cyc <= cyc) begin
            p = pay_q.pop_front();
            chk("pay_slot", 32'(p.cyc), 32'(cyc));
            chk("bubble_out", 32'(bubble_out), 32'(p.bub));
            chk("is_misaligned_out", 32'(is_misaligned_out), 32'(p.mis));
            chk("opcode_out", 32'(opcode_out), 32'(p.opc));
            chk("is_load_out", 32'(is_load_out), 32'(p.ld));
            chk("is_store_out", 32'(is_store_out), 32'(p.st));
            chk("addr_out", addr_out, p.addr);
            chk("tgt_out_1", 32'(tgt_out_1), 32'(p.t1));
            chk("tgt_out_2", 32'(tgt_out_2), 32'(p.t2));
            chk("alu_result_1_out", alu_result_1_out, p.a1);
            chk("alu_result_2_out", alu_result_2_out, p.a2);
            chk("exc_out", 32'(exc_out), 32'(p.exc));
            chk("sideband_out", 32'(sideband_out), 32'(p.sb));
        end
    end

    initial begin : stim
        op_t idle;
        op_t op;
        idle = mk(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00);
        idle.bub = 1'b1;
        rst_cycle(idle);
        rst_cycle(idle);
        run_op(mk(5'd3, 1'b0, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 8'h00), 2, -1);
        run_op(mk(5'd9, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_005A, 8'h00), 2, -1);
        run_op(mk(5'd3, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 8'h00), 2, -1);
        run_op(mk(5'd3, 1'b0, 1'b1, 32'h0000_0101, 32'h1122_3344, 8'h00), 2, -1);
        run_op(mk(5'd6, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_BEEF, 8'h00), 2, 2);
        run_op(mk(5'd3, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 8'h02), 2, -1);
        op = mk(5'd3, 1'b0, 1'b1, 32'h0000_0101, 32'hCAFE_F00D, 8'h00);
        run_op(op, 1, -1);
        rst_cycle(op);
        for (int i = 0; i < 400; i++) begin
            op = rand_op();
            run_op(op, 2, -1);
            if ($urandom_range(0, 49) == 0) begin
                op = rand_op();
                op.bub = 1'b0; op.exc = 8'h00; op.opc = 5'd4; op.st = 1'b1; op.ld = 1'b0;
                op.addr[1:0] = 2'($urandom_range(1, 3));
                run_op(op, 1, -1);
                rst_cycle(op);
            end
        end
        drive(idle, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) @(posedge clk);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("pay_queue_drained", 32'(pay_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
